mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multiply/divide unit for the P6 pipelined MIPS core, located in the E stage beside the ALU. It consumes `MDOp`, `HLOp` and `MDStart` from the controller, plus the forwarded rs/rt operands. It holds the architectural HI/LO registers and models multi-cycle latency with a `Busy` flag. The hazard unit uses `Busy` to stall the pipeline.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `MDStart` in 1: 1 for mult/multu/div/divu in E.
- `MDOp` in 3: operation code. OTH=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
- `HLOp` in 1: read select. 0=LO, 1=HI.
- `A` in 32: rs value, after forwarding.
- `B` in 32: rt value, after forwarding.
- `Busy` out 1: operation in flight.
- `HLOut` out 32: `HLOp ? HI : LO`. Combinational from the registers.

## Operation
- State: HI[31:0], LO[31:0], cnt (4 bits, sized to the larger of the two parameters), pendHI, pendLO, pendWr.
- `Busy` = (cnt != 0).
- Idle (`Busy`=0) with `MDStart`=1, the result is computed from `A`/`B` at the edge:
  - MULT: {pendHI,pendLO} = signed A×B, 64-bit.
  - MULTU: {pendHI,pendLO} = unsigned A×B, 64-bit.
  - DIV: pendLO = signed quotient, truncated toward zero. pendHI = remainder, with the sign of the dividend.
  - DIVU: pendLO = unsigned quotient. pendHI = unsigned remainder.
  - DIV/DIVU with B=0: pendWr=0. HI/LO stay unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - cnt loads MULT_CYCLES for MULT/MULTU and DIV_CYCLES for DIV/DIVU.
  - pendWr=1, except for divide-by-zero.
  - `MDStart`=1 with `MDOp` ∉ {1..4}: no effect.
- Busy: cnt decrements every edge. On the edge where cnt==1:
  - cnt←0.
  - If pendWr: HI←pendHI, LO←pendLO.
- Idle with `MDStart`=0:
  - `MDOp`=MTHI: HI←A at the edge.
  - `MDOp`=MTLO: LO←A at the edge.
  - Any other `MDOp`: no change.
- While `Busy`=1, `MDStart` and MTHI/MTLO are ignored and HI/LO are held. The hazard unit is required never to issue them, but the block stays safe if it does.
- `HLOut` during `Busy` shows the old HI/LO. Stalling mfhi/mflo is the hazard unit's job.
- Reset (`reset`=0 at an edge) overrides everything, including mid-operation:
  - HI=0, LO=0, cnt=0, pendWr=0, so `Busy`=0.
  - An in-flight result is discarded.

## Timing
- Start edge at edge E0:
  - `Busy` is 1 in the cycles following E0 … E(N−1), exactly N cycles, where N = MULT_CYCLES or DIV_CYCLES.
  - `Busy` falls and HI/LO update at edge EN.
  - The new value is visible on `HLOut` in the first cycle with `Busy`=0.
- MTHI/MTLO: 1-cycle. The value is visible on `HLOut` in the cycle after the edge.
- Back-to-back: a new `MDStart` is accepted in the first cycle after `Busy` falls (edge EN+1).
- All outputs after reset: `Busy`=0, `HLOut`=0.

## Test plan
- Reset then idle: `reset`=0 for 2 edges → `Busy`=0, `HLOut`=0 for both `HLOp` values.
- MULT A=0xFFFFFFFF B=2 → `Busy`=1 for exactly 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU, same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7) B=2:
  - `Busy` is high for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7 B=2 → LO=3, HI=1.
- DIV with B=0 after MTHI A=0x1234 and MTLO A=0x5678:
  - The MTHI/MTLO values appear 1 cycle after each edge.
  - After 10 busy cycles, HI=0x1234 and LO=0x5678 are unchanged.
- Start MULT, then assert `reset`=0 at busy cycle 3:
  - `Busy`=0 and HI=LO=0 from the next cycle.
  - No late write-back occurs.
- During `Busy`, drive `MDStart`=1 DIVU and an MTHI:
  - Both are ignored.
  - The original MULT result is written on schedule.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit
//
// Multiply/divide unit for the E stage of the pipelined MIPS core. It owns
// the architectural HI/LO registers. Results are computed in the start
// cycle and held in pending registers. Write-back to HI/LO is delayed by a
// countdown so that the pipeline sees a realistic multi-cycle latency.
//
// Ports:
//   clk      in  1   rising-edge clock
//   reset    in  1   synchronous, active-low
//   MDStart  in  1   start mult/multu/div/divu (operation selected by MDOp)
//   MDOp     in  3   OTH=0 MULT=1 MULTU=2 DIV=3 DIVU=4 MTHI=5 MTLO=6
//   HLOp     in  1   read select for HLOut: 0=LO, 1=HI
//   A        in  32  rs operand (forwarded)
//   B        in  32  rt operand (forwarded)
//   Busy     out 1   operation in flight
//   HLOut    out 32  HLOp ? HI : LO, combinational from the registers
//
// Handshake: Busy acts as an inverted ready. A start (MDStart=1 with a
// mult/div MDOp) or an MTHI/MTLO (MDStart=0) is accepted only on an edge
// where Busy=0. Anything presented while Busy=1 is dropped without effect.
// HLOut always shows the committed HI/LO, never the pending result.

module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDStart,
  input  logic [2:0]  MDOp,
  input  logic        HLOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HLOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_OTH   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_wr;
  logic [CNT_W-1:0] cnt;

  // Arithmetic datapath, evaluated every cycle from the current operands.
  logic [63:0]        smul;
  logic [63:0]        umul;
  logic               div_by_zero;
  logic               div_ovf;
  logic [31:0]        b_safe;
  logic signed [31:0] sdiv_q;
  logic signed [31:0] sdiv_r;
  logic [31:0]        squot;
  logic [31:0]        srem;
  logic [31:0]        uquot;
  logic [31:0]        urem;

  always_comb begin
    smul        = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    umul        = {32'h0, A} * {32'h0, B};
    div_by_zero = (B == 32'h0);
    // The divider never sees zero; the result is discarded in that case.
    b_safe      = div_by_zero ? 32'h1 : B;
    // -2^31 / -1 overflows; the architected result is LO=0x80000000, HI=0.
    div_ovf     = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    sdiv_q      = $signed(A) / $signed(b_safe);
    sdiv_r      = $signed(A) % $signed(b_safe);
    squot       = div_ovf ? 32'h8000_0000 : sdiv_q;
    srem        = div_ovf ? 32'h0 : sdiv_r;
    uquot       = A / b_safe;
    urem        = A % b_safe;
  end

  // Decode of a start request: which result, how long, and whether it
  // will be committed at the end.
  logic             start_ok;
  logic [CNT_W-1:0] start_cnt;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_wr;

  always_comb begin
    start_ok  = 1'b0;
    start_cnt = '0;
    res_hi    = 32'h0;
    res_lo    = 32'h0;
    res_wr    = 1'b1;
    case (MDOp)
      OP_MULT: begin
        start_ok         = 1'b1;
        start_cnt        = CNT_W'(MULT_CYCLES);
        {res_hi, res_lo} = smul;
      end
      OP_MULTU: begin
        start_ok         = 1'b1;
        start_cnt        = CNT_W'(MULT_CYCLES);
        {res_hi, res_lo} = umul;
      end
      OP_DIV: begin
        start_ok  = 1'b1;
        start_cnt = CNT_W'(DIV_CYCLES);
        res_lo    = squot;
        res_hi    = srem;
        res_wr    = !div_by_zero;
      end
      OP_DIVU: begin
        start_ok  = 1'b1;
        start_cnt = CNT_W'(DIV_CYCLES);
        res_lo    = uquot;
        res_hi    = urem;
        res_wr    = !div_by_zero;
      end
      default: begin
        start_ok = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi      <= 32'h0;
      lo      <= 32'h0;
      cnt     <= '0;
      pend_hi <= 32'h0;
      pend_lo <= 32'h0;
      pend_wr <= 1'b0;
    end else if (cnt != '0) begin
      // In flight: count down, commit on the final busy edge, ignore inputs.
      cnt <= cnt - CNT_W'(1);
      if ((cnt == CNT_W'(1)) && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (MDStart) begin
      if (start_ok) begin
        cnt     <= start_cnt;
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= res_wr;
      end
    end else begin
      case (MDOp)
        OP_MTHI: hi <= A;
        OP_MTLO: lo <= A;
        OP_OTH:  ;
        default: ;
      endcase
    end
  end

  assign Busy  = (cnt != '0);
  assign HLOut = HLOp ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit.
// A driver issues directed and random operations and pushes the expected
// busy length and resulting HI/LO into exp_q. A monitor follows the DUT
// cycle by cycle, pops an entry whenever an operation is accepted, and
// compares Busy and both HI and LO (via HLOut) every cycle.

module tb_mult_div_unit;

  localparam int W = 72;  // {busy_len[7:0], hi[31:0], lo[31:0]}

  logic        clk = 1'b0;
  logic        reset;
  logic        MDStart;
  logic [2:0]  MDOp;
  logic        HLOp = 1'b0;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HLOut;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .MDStart (MDStart),
    .MDOp    (MDOp),
    .HLOp    (HLOp),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .HLOut   (HLOut)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [31:0]  model_hi = 32'h0;
  logic [31:0]  model_lo = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_accepted(input logic st, input logic [2:0] op);
    if (st) return (op >= 3'd1) && (op <= 3'd4);
    return (op == 3'd5) || (op == 3'd6);
  endfunction

  // ---------------- reference model ----------------
  // Returns {busy_len, new_hi, new_lo} for an accepted operation, from
  // plain 64-bit integer arithmetic on the committed HI/LO.
  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    logic [31:0] nh;
    logic [31:0] nl;
    int          n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    nh = model_hi;
    nl = model_lo;
    n  = 0;
    case (op)
      3'd1: begin p = 64'(sa * sb); nh = p[63:32]; nl = p[31:0]; n = 5; end
      3'd2: begin p = 64'(ua * ub); nh = p[63:32]; nl = p[31:0]; n = 5; end
      3'd3: begin
        n = 10;
        if (b != 32'h0) begin
          p  = 64'(sa / sb);
          nl = p[31:0];
          p  = 64'(sa % sb);
          nh = p[31:0];
        end
      end
      3'd4: begin
        n = 10;
        if (b != 32'h0) begin
          p  = 64'(ua / ub);
          nl = p[31:0];
          p  = 64'(ua % ub);
          nh = p[31:0];
        end
      end
      3'd5: nh = a;
      3'd6: nl = a;
      default: ;
    endcase
    return {8'(n), nh, nl};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      MDStart = 1'b0;
      MDOp    = 3'd0;
      A       = $urandom;
      B       = $urandom;
    end
  endtask

  // Issue one operation. While the unit is busy, optionally throw random
  // (to-be-ignored) requests at it. abort_at>0 pulls reset low for busy edge
  // number abort_at.
  task automatic do_op(input logic st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int abort_at, input bit junk);
    logic [W-1:0] e;
    int           n;
    n = 0;
    e = {8'd0, model_hi, model_lo};
    if (is_accepted(st, op)) begin
      e = ref_op(op, a, b);
      n = int'(e[71:64]);
      exp_q.push_back(e);
    end
    @(negedge clk);
    MDStart = st;
    MDOp    = op;
    A       = a;
    B       = b;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        reset    = 1'b0;
        MDStart  = 1'b0;
        MDOp     = 3'd0;
        model_hi = 32'h0;
        model_lo = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (junk) begin
        MDStart = 1'($urandom);
        MDOp    = 3'($urandom);
        A       = $urandom;
        B       = $urandom;
      end else begin
        MDStart = 1'b0;
        MDOp    = 3'd0;
      end
    end
    model_hi = e[63:32];
    model_lo = e[31:0];
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  int           rem = 0;
  logic [31:0]  cur_hi = 32'h0;
  logic [31:0]  cur_lo = 32'h0;
  logic [31:0]  pnd_hi = 32'h0;
  logic [31:0]  pnd_lo = 32'h0;
  logic [W-1:0] me;

  always @(posedge clk) begin
    if (reset !== 1'b1) begin
      rem    = 0;
      cur_hi = 32'h0;
      cur_lo = 32'h0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        cur_hi = pnd_hi;
        cur_lo = pnd_lo;
      end
    end else if (is_accepted(MDStart, MDOp)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL exp_q_empty: got accept with op %0d expected queued entry at %0t",
                 MDOp, $time);
      end else begin
        me     = exp_q.pop_front();
        rem    = int'(me[71:64]);
        pnd_hi = me[63:32];
        pnd_lo = me[31:0];
        if (rem == 0) begin
          cur_hi = pnd_hi;
          cur_lo = pnd_lo;
        end
      end
    end
    #1;
    check("busy", {31'h0, Busy}, {31'h0, (rem > 0)});
    HLOp = 1'b0;
    #1;
    check("lo", HLOut, cur_lo);
    HLOp = 1'b1;
    #1;
    check("hi", HLOut, cur_hi);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] bad_start[4];
    logic [2:0] bad_idle[6];
    int         r;
    bad_start = '{3'd0, 3'd5, 3'd6, 3'd7};
    bad_idle  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

    reset   = 1'b0;
    MDStart = 1'b0;
    MDOp    = 3'd0;
    A       = 32'h0;
    B       = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Directed cases
    do_op(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h2, 0, 1'b0);  // MULT
    do_op(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h2, 0, 1'b0);  // MULTU
    do_op(1'b1, 3'd3, 32'hFFFF_FFF9, 32'h2, 0, 1'b0);  // DIV -7/2
    do_op(1'b1, 3'd4, 32'h7, 32'h2, 0, 1'b0);          // DIVU 7/2
    idle(1);
    do_op(1'b0, 3'd5, 32'h1234, 32'h0, 0, 1'b0);       // MTHI
    do_op(1'b0, 3'd6, 32'h5678, 32'h0, 0, 1'b0);       // MTLO
    do_op(1'b1, 3'd3, 32'h9999, 32'h0, 0, 1'b0);       // DIV by zero
    idle(2);
    do_op(1'b1, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 3, 1'b0);  // reset mid-op
    idle(8);
    do_op(1'b1, 3'd1, 32'h0001_0003, 32'h0002_0005, 0, 1'b1);  // ignored requests
    do_op(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);  // DIV overflow
    do_op(1'b1, 3'd5, 32'h1, 32'h1, 0, 1'b0);                  // invalid start
    do_op(1'b0, 3'd1, 32'h1, 32'h1, 0, 1'b0);                  // idle MULT code
    idle(2);

    // Random traffic
    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 19);
      if (r < 12)
        do_op(1'b1, 3'($urandom_range(1, 4)), pick_val(), pick_val(), 0, 1'($urandom));
      else if (r < 14)
        do_op(1'b0, 3'($urandom_range(5, 6)), $urandom, $urandom, 0, 1'b0);
      else if (r == 14)
        do_op(1'b1, bad_start[$urandom_range(0, 3)], $urandom, $urandom, 0, 1'b0);
      else if (r == 15)
        do_op(1'b0, bad_idle[$urandom_range(0, 5)], $urandom, $urandom, 0, 1'b0);
      else if (r == 16)
        do_op(1'b1, 3'($urandom_range(1, 4)), $urandom, pick_val(),
              $urandom_range(1, 5), 1'($urandom));
      else
        idle($urandom_range(1, 3));
    end

    idle(4);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
